// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//
// Purpose:
//   Tracks architectural registers that have outstanding long-latency writes
//   (loads, mul/div) and holds decode until each result exists. It sits beside
//   ID and looks at the same Rs1/Rs2 view as the forwarding unit. Whenever the
//   forwarding unit picks a value, this block's stall guarantees that value is
//   valid.
//
//   Each register has a small saturating pending counter. Issue of an accepted
//   long-latency write increments it, and a write-back completion decrements
//   it. A flush clears every counter. Register x0 is never tracked.
//
// Optional feature (compile-time macro SCOREBOARD_PERF_EN):
//   When defined, adds StallCntOut, a saturating count of stall cycles.
//   When undefined, that port and its counter are absent.
//
// Ports:
//   Clk               in   core clock, rising edge
//   Rst               in   asynchronous active-low reset
//   IssueValidIn      in   ID presents an instruction this cycle
//   IssueRdEnableIn   in   instruction writes Rd
//   IssueRdAddrIn     in   destination register
//   IssueLongLatIn    in   result not available from EX (load/mul/div)
//   Rs1AddrRegFileIn  in   source 1 address
//   Rs1ReadEnableIn   in   source 1 used
//   Rs2AddrRegFileIn  in   source 2 address
//   Rs2ReadEnableIn   in   source 2 used
//   CompleteValidIn   in   a long-latency result is written back this cycle
//   CompleteRdAddrIn  in   register of that result
//   FlushIn           in   pipeline flush, kills all tracked writes
//   StallOut          out  hold IF/ID, insert bubble into EX (combinational)
//   IssueAcceptOut    out  instruction leaves ID this cycle
//   BusyOut           out  any pending counter non-zero
//   ErrOut            out  sticky protocol error (completion with nothing pending)
//   StallCntOut       out  stall-cycle counter (SCOREBOARD_PERF_EN only)
// -----------------------------------------------------------------------------
module reg_scoreboard #(
    parameter int REG_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int PEND_W  = 2,
    parameter int PERF_W  = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IssueValidIn,
    input  logic              IssueRdEnableIn,
    input  logic [ADDR_W-1:0] IssueRdAddrIn,
    input  logic              IssueLongLatIn,
    input  logic [ADDR_W-1:0] Rs1AddrRegFileIn,
    input  logic              Rs1ReadEnableIn,
    input  logic [ADDR_W-1:0] Rs2AddrRegFileIn,
    input  logic              Rs2ReadEnableIn,
    input  logic              CompleteValidIn,
    input  logic [ADDR_W-1:0] CompleteRdAddrIn,
    input  logic              FlushIn,
    output logic              StallOut,
    output logic              IssueAcceptOut,
    output logic              BusyOut,
    output logic              ErrOut
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [PERF_W-1:0] StallCntOut
`endif
);

    localparam logic [PEND_W-1:0] CNT_ZERO = '0;
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_X0  = '0;

    // Flattened view of every per-register counter, driven from the generate loop.
    logic [PEND_W-1:0] pend_cnt [REG_NUM];
    logic [REG_NUM-1:0] pend_nz;

    logic [PEND_W-1:0] rs1_cnt;
    logic [PEND_W-1:0] rs2_cnt;
    logic [PEND_W-1:0] iss_cnt;
    logic [PEND_W-1:0] cmp_cnt;

    logic hit1;
    logic hit2;
    logic full;
    logic stall;
    logic accept;
    logic inc;
    logic dec;
    logic err_q;
    logic err_d;

    assign rs1_cnt = pend_cnt[Rs1AddrRegFileIn];
    assign rs2_cnt = pend_cnt[Rs2AddrRegFileIn];
    assign iss_cnt = pend_cnt[IssueRdAddrIn];
    assign cmp_cnt = pend_cnt[CompleteRdAddrIn];

    // A source whose last outstanding write completes this very cycle is
    // forwarded from WB, so it must not stall. With more than one write still
    // pending the register remains unresolved even while one completes.
    always_comb begin
        hit1 = Rs1ReadEnableIn && (Rs1AddrRegFileIn != ADDR_X0) && (rs1_cnt != CNT_ZERO)
               && !(CompleteValidIn && (CompleteRdAddrIn == Rs1AddrRegFileIn) && (rs1_cnt == CNT_ONE));
        hit2 = Rs2ReadEnableIn && (Rs2AddrRegFileIn != ADDR_X0) && (rs2_cnt != CNT_ZERO)
               && !(CompleteValidIn && (CompleteRdAddrIn == Rs2AddrRegFileIn) && (rs2_cnt == CNT_ONE));
        // A saturated counter can still absorb a new issue if a completion frees a slot now.
        full = IssueRdEnableIn && IssueLongLatIn && (IssueRdAddrIn != ADDR_X0)
               && (iss_cnt == CNT_MAX)
               && !(CompleteValidIn && (CompleteRdAddrIn == IssueRdAddrIn));
    end

    assign stall  = IssueValidIn && !FlushIn && (hit1 || hit2 || full);
    assign accept = IssueValidIn && !stall && !FlushIn;
    assign inc    = accept && IssueRdEnableIn && IssueLongLatIn && (IssueRdAddrIn != ADDR_X0);
    assign dec    = CompleteValidIn && (CompleteRdAddrIn != ADDR_X0) && (cmp_cnt != CNT_ZERO);

    // Completion to a tracked register with nothing outstanding is a protocol error.
    assign err_d  = err_q || (CompleteValidIn && (CompleteRdAddrIn != ADDR_X0) && (cmp_cnt == CNT_ZERO));

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

            logic [PEND_W-1:0] cnt_q;
            logic [PEND_W-1:0] cnt_d;
            logic              inc_here;
            logic              dec_here;

            assign inc_here = inc && (IssueRdAddrIn == IDX);
            assign dec_here = dec && (CompleteRdAddrIn == IDX);

            always_comb begin
                cnt_d = cnt_q;
                if (FlushIn) begin
                    cnt_d = CNT_ZERO;
                end else if (inc_here && !dec_here) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (dec_here && !inc_here) begin
                    // dec already guarantees a non-zero count
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            always_ff @(posedge Clk or negedge Rst) begin
                if (!Rst) begin
                    cnt_q <= CNT_ZERO;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign pend_cnt[gi] = cnt_q;
            assign pend_nz[gi]  = (cnt_q != CNT_ZERO);
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign StallOut       = stall;
    assign IssueAcceptOut = accept;
    assign BusyOut        = |pend_nz;
    assign ErrOut         = err_q;

`ifdef SCOREBOARD_PERF_EN
    localparam logic [PERF_W-1:0] PERF_MAX = '1;
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != PERF_MAX)) begin
            stall_cnt_d = stall_cnt_q + PERF_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCntOut = stall_cnt_q;
`endif

endmodule
